// File: rtl/myproject_sdiv_25s_9ns_16_seq.sv
// Sequential signed-by-unsigned divider: one restoring step per enabled cycle,
// fixed latency, saturating quotient with divide-by-zero flag.
module myproject_sdiv_25s_9ns_16_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 25,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  dout_vld,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  ovf,
    output logic                  dz
);

    localparam int CW = $clog2(din0_WIDTH + 1);

    localparam logic [din0_WIDTH-1:0] QMAX =
        din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
    localparam logic [din0_WIDTH-1:0] QMAG = QMAX + 1'b1;

    localparam logic [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [din0_WIDTH-1:0]   quo;
    logic [din1_WIDTH-1:0]   part;
    logic [din1_WIDTH-1:0]   dvs;
    logic                    neg;

    logic [din1_WIDTH:0]     shifted;
    logic [din1_WIDTH+1:0]   trial;
    logic [din0_WIDTH-1:0]   qneg;
    logic [din1_WIDTH:0]     rext;
    logic                    sat_pos;
    logic                    sat_neg;
    logic                    unused_ok;

    // Partial remainder stays below the divisor, so din1_WIDTH bits suffice.
    assign shifted = {part, quo[din0_WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs};
    assign qneg    = '0 - quo;
    assign rext    = {1'b0, part};
    assign sat_pos = !neg && (quo > QMAX);
    assign sat_neg = neg && (quo > QMAG);

    assign busy     = (state != IDLE);
    assign dout_vld = (state == DONE);

    assign unused_ok = ^{32'(ID), qneg[din0_WIDTH-1:dout_WIDTH],
                         trial[din1_WIDTH]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            quo  <= '0;
            part <= '0;
            dvs  <= '0;
            neg  <= 1'b0;
            dout <= '0;
            rem  <= '0;
            ovf  <= 1'b0;
            dz   <= 1'b0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        neg  <= din0[din0_WIDTH-1];
                        quo  <= din0[din0_WIDTH-1] ? ('0 - din0) : din0;
                        dvs  <= din1;
                        part <= '0;
                        cnt  <= CW'(din0_WIDTH);
                    end
                end
                CALC: begin
                    quo <= {quo[din0_WIDTH-2:0], ~trial[din1_WIDTH+1]};
                    part <= trial[din1_WIDTH+1] ? shifted[din1_WIDTH-1:0]
                                                : trial[din1_WIDTH-1:0];
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (dvs == '0) begin
                        dz   <= 1'b1;
                        ovf  <= 1'b1;
                        rem  <= '0;
                        dout <= neg ? DMIN : DMAX;
                    end else begin
                        dz  <= 1'b0;
                        ovf <= sat_pos | sat_neg;
                        rem <= neg ? ('0 - rext) : rext;
                        if (sat_pos) begin
                            dout <= DMAX;
                        end else if (sat_neg) begin
                            dout <= DMIN;
                        end else begin
                            dout <= neg ? qneg[dout_WIDTH-1:0]
                                        : quo[dout_WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_myproject_sdiv_25s_9ns_16_seq.sv
// Scoreboard bench for the sequential divider: the driver pushes results from
// an arithmetic model, the monitor pops them whenever dout_vld is consumed.
module tb_myproject_sdiv_25s_9ns_16_seq;

    localparam int LAT = 27;

    typedef struct {
        logic [15:0] q;
        logic [9:0]  r;
        logic        ovf;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [24:0] din0 = '0;
    logic [8:0]  din1 = '0;
    logic        busy;
    logic        dout_vld;
    logic [15:0] dout;
    logic [9:0]  rem;
    logic        ovf;
    logic        dz;

    exp_t sbq[$];
    exp_t last;
    int   wcyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    myproject_sdiv_25s_9ns_16_seq #(
        .ID(1), .din0_WIDTH(25), .din1_WIDTH(9), .dout_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .dout_vld(dout_vld),
        .dout(dout), .rem(rem), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) wcyc <= wcyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint qt;
        longint r;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.lat = 0;
        e.acc = 0;
        if (b == 0) begin
            e.dz  = 1'b1;
            e.ovf = 1'b1;
            e.r   = '0;
            e.q   = (a >= 0) ? 16'h7fff : 16'h8000;
        end else begin
            qt  = a / b;
            r   = a % b;
            e.r = 10'(r);
            if (qt > 32767) begin
                e.q = 16'h7fff;
                e.ovf = 1'b1;
            end else if (qt < -32768) begin
                e.q = 16'h8000;
                e.ovf = 1'b1;
            end else begin
                e.q = 16'(qt);
            end
        end
        return e;
    endfunction

    task automatic issue(input logic signed [24:0] a, input logic [8:0] b,
                         input int lat);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        check("hold_dout", 32'(dout), 32'(last.q));
        check("hold_rem", 32'(rem), 32'(last.r));
        check("hold_flags", 32'({ovf, dz}), 32'({last.ovf, last.dz}));
        e = model(longint'(a), longint'({1'b0, b}));
        e.acc = wcyc;
        e.lat = lat;
        sbq.push_back(e);
        start = 1'b1;
        din0  = a;
        din1  = b;
        @(negedge clk);
        start = 1'b0;
        din0  = 25'($urandom);
        din1  = 9'($urandom);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset && dout_vld && ce) begin
                if (sbq.size() == 0) begin
                    check("spurious_vld", 32'(dout_vld), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("dout", 32'(dout), 32'(e.q));
                    check("rem", 32'(rem), 32'(e.r));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("dz", 32'(dz), 32'(e.dz));
                    check("latency", 32'(wcyc - e.acc), 32'(e.lat));
                    last = e;
                end
            end
        end
    end

    initial begin : stim
        int t;
        last.q = '0;
        last.r = '0;
        last.ovf = 1'b0;
        last.dz = 1'b0;
        last.lat = 0;
        last.acc = 0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_flags", 32'({ovf, dz}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(25'(1000), 9'd7, LAT);
        issue(25'(-1000), 9'd7, LAT);
        issue(25'(16777215), 9'd1, LAT);
        issue(25'(-16744448), 9'd511, LAT);
        issue(25'(5), 9'd0, LAT);
        issue(25'(-5), 9'd0, LAT);
        issue(25'(-16777216), 9'd1, LAT);
        issue(25'(-98304), 9'd3, LAT);
        issue(25'(65536), 9'd2, LAT);
        issue(25'(32767), 9'd1, LAT);
        issue(25'(0), 9'd5, LAT);

        // ce stalls mid-calculation plus ignored starts with new operands
        issue(25'(777777), 9'd300, LAT + 10);
        repeat (5) @(negedge clk);
        start = 1'b1;
        din0  = 25'($urandom);
        din1  = '0;
        @(negedge clk);
        start = 1'b0;
        check("busy_inflight", 32'(busy), 32'd1);
        ce = 1'b0;
        repeat (10) @(negedge clk);
        ce = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // reset aborts an operation without a strobe
        issue(25'(-12345), 9'd77, LAT);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_vld", 32'(dout_vld), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_rem", 32'(rem), 32'd0);
        check("abort_flags", 32'({ovf, dz}), 32'd0);
        sbq.delete(sbq.size() - 1);
        last.q = '0;
        last.r = '0;
        last.ovf = 1'b0;
        last.dz = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(25'(100), 9'd3, LAT);

        for (int i = 0; i < 25; i++) begin
            logic signed [24:0] a;
            logic [8:0]         b;
            a = 25'($urandom);
            a = a >>> $urandom_range(0, 22);
            b = 9'($urandom);
            if ($urandom_range(0, 9) == 0) b = '0;
            issue(a, b, LAT);
        end

        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/myproject_sdiv_25s_9ns_16_seq.md
MYPROJECT_SDIV_25S_9NS_16_SEQ -- requirements
Module: myproject_sdiv_25s_9ns_16_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag, no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 25, dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 9, divisor width.
REQ-004 SHALL have parameter dout_WIDTH, default 16, quotient width.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port ce  in  1  clock enable; when 0, all state and outputs hold.
REQ-008 SHALL have port start  in  1  request; sampled only in IDLE with ce=1.
REQ-009 SHALL have port din0  in  din0_WIDTH  signed dividend.
REQ-010 SHALL have port din1  in  din1_WIDTH  unsigned divisor.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port dout_vld  out  1  one-cycle result strobe.
REQ-013 SHALL have port dout  out  dout_WIDTH  signed quotient, truncated toward zero, saturated.
REQ-014 SHALL have port rem  out  din1_WIDTH+1  signed remainder, sign of dividend.
REQ-015 SHALL have port ovf  out  1  quotient saturated (includes divide-by-zero).
REQ-016 SHALL have port dz  out  1  divisor was zero.

Function
REQ-017 SHALL implement states IDLE, CALC, FIX, DONE; unsigned restoring division, one quotient bit per ce-enabled cycle.
REQ-018 IDLE: start=1 and ce=1 SHALL capture |din0|, din0 sign, din1 and go to CALC; iteration counter loaded with din0_WIDTH.
REQ-019 CALC SHALL last exactly din0_WIDTH (25) ce-enabled cycles, then go to FIX.
REQ-020 FIX SHALL apply sign, saturation and dz handling, register dout/rem/ovf/dz, go to DONE.
REQ-021 DONE SHALL assert dout_vld for one ce-enabled cycle, then return to IDLE.
REQ-022 Latency SHALL be fixed: dout_vld high exactly 27 ce-enabled cycles after the start-accept cycle, independent of operands.
REQ-023 Throughput: next start SHALL be accepted no earlier than the IDLE cycle after DONE; start while busy SHALL be ignored, not queued.
REQ-024 Quotient magnitude >32767 with positive result SHALL give dout=+32767, ovf=1; magnitude >32768 with negative result SHALL give dout=-32768, ovf=1; -32768 exactly SHALL not set ovf.
REQ-025 din1=0 SHALL give dz=1, ovf=1, rem=0, dout=+32767 if din0>=0 else -32768; latency unchanged.
REQ-026 Remainder SHALL satisfy din0 = q_true*din1 + rem with |rem|<din1, using the unsaturated quotient.
REQ-027 dout, rem, ovf, dz SHALL hold their last values until overwritten in FIX of the next operation.
REQ-028 ce=0 in any state SHALL freeze state, counter, datapath and outputs, including a pending dout_vld.
REQ-029 din0/din1 changes after the accept cycle SHALL not affect the in-flight result.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, counter=0, busy=0, dout_vld=0, dout=0, rem=0, ovf=0, dz=0.
REQ-031 reset asserted mid-operation SHALL abort it with no dout_vld; first start after release SHALL be accepted normally.
REQ-032 Deassertion SHALL be synchronised externally; the block SHALL take no action in the cycle reset is released other than sampling start.

Verification
REQ-033 din0=1000, din1=7, start -> 27 cycles later dout_vld=1, dout=142, rem=6, ovf=0, dz=0.
REQ-034 din0=-1000, din1=7 -> dout=-142, rem=-6, ovf=0.
REQ-035 din0=16777215, din1=1 -> dout=32767, ovf=1; din0=-16744448, din1=511 -> dout=-32768, rem=0, ovf=0.
REQ-036 din0=5, din1=0 -> dout=32767, rem=0, dz=1, ovf=1, still 27-cycle latency.
REQ-037 Start, toggle ce low for 10 cycles mid-CALC -> dout_vld at cycle 37, correct result; start pulses while busy ignored.
REQ-038 Start, assert reset at cycle 12 -> all outputs 0, no dout_vld; new start 100/3 -> dout=33, rem=1.
